mul_acc: RTL and testbench
==========================

// Module: mul_acc
// PURPOSE
//  Sequential signed shift-add multiply-accumulate: result = multiplicand * multiplier + addend.
//  Inverse datapath of the sequential divider: feeding quotient, divisor and remainder back
//  in reconstructs the dividend, for division self-check.
//  Also serves the FM demod chain as a small-area multiplier where one result per
//  B_WIDTH+2 cycles is enough.
// PARAMETERS
//  A_WIDTH  32  multiplicand width, two's complement
//  B_WIDTH  32  multiplier and addend width, two's complement; equals LOOP iteration count
//  P_WIDTH  A_WIDTH+B_WIDTH  result width (derived; not to be overridden)
// PORTS
//  clk           in   1        single clock, all state on rising edge
//  reset         in   1        synchronous, active-high
//  valid_in      in   1        operand strobe; sampled only in IDLE
//  multiplicand  in   A_WIDTH  signed
//  multiplier    in   B_WIDTH  signed
//  addend        in   B_WIDTH  signed, sign-extended to P_WIDTH before the add
//  busy          out  1        high in LOOP and EPILOGUE
//  result        out  P_WIDTH  signed product plus addend; held until the next completion
//  valid_out     out  1        one-cycle completion pulse
// BEHAVIOUR
//  - Reset (synchronous): state=IDLE; result, valid_out, busy, all internal regs = 0.
//    Reset mid-operation aborts the operation; no valid_out is produced for it.
//  - FSM states: IDLE, LOOP, EPILOGUE.
//  - IDLE: on edge k with valid_in=1:
//    - Latch sign = multiplicand MSB ^ multiplier MSB, and the addend.
//    - Latch |multiplicand| (A_WIDTH unsigned) and |multiplier| (B_WIDTH unsigned);
//      |-2^(W-1)| = 2^(W-1) is representable unsigned.
//    - acc=0, cnt=0; go to LOOP.
//  - LOOP, one edge per bit, LSB first:
//    - If mplr[0]=1: acc += mcand << cnt (P_WIDTH unsigned).
//    - mplr >>= 1; cnt++.
//    - After exactly B_WIDTH edges (cnt reaches B_WIDTH-1 then advances), go to EPILOGUE.
//    - Fixed latency; no early exit on zero operands.
//  - EPILOGUE, edge k+B_WIDTH+1:
//    - result <= (sign ? -acc : acc) + sext(addend), modulo 2^P_WIDTH.
//    - valid_out <= 1; go to IDLE.
//  - Latency: valid_in sampled at edge k gives valid_out high in the cycle after edge
//    k+B_WIDTH+1, for exactly one cycle.
//  - Arithmetic is exact: |product| <= 2^(P_WIDTH-2), so adding any B_WIDTH addend never
//    wraps P_WIDTH. No overflow flag.
//  - valid_in while busy=1 is ignored: no queueing, latched operands unchanged.
//  - Back-to-back: valid_in high in the valid_out cycle (state already IDLE) is accepted;
//    throughput is one op per B_WIDTH+2 cycles.
//  - Inputs only need to be stable at the accept edge.
//  - result changes only at EPILOGUE or reset; never X after reset.
// TESTING
//  1. a=7, b=-3, c=0 -> result=-21 (0xFFFF_FFFF_FFFF_FFEB), valid_out exactly 33 edges
//     after accept.
//  2. a=-2^31, b=-2^31, c=2^31-1 -> result=0x4000_0000_7FFF_FFFF, no wrap.
//  3. Divider round trip: q=142857, b=7, r=1 -> 1000000; q=-142857, b=7, r=-1 -> -1000000.
//  4. a=0, b=-1, c=-5 -> result=-5; a=-1, b=-1, c=0 -> 1.
//  5. valid_in pulsed at cycles 5 and 10 after an accept -> ignored; exactly one valid_out
//     with first operands. Then valid_in held high continuously -> completions every 34 cycles.
//  6. reset asserted at LOOP cnt=10 -> next cycle IDLE, result=0, busy=0, no valid_out;
//     a fresh op then completes correctly.
//  Plus a random signed sweep (>=10k ops) against a behavioural model, including
//  0/+-1/min/max corners.

Source files
------------

// File: rtl/mul_acc.sv
// Sequential signed shift-add multiply-accumulate: result = multiplicand * multiplier + addend.
// One result per B_WIDTH+2 cycles; operands offered while busy are dropped, not queued.
module mul_acc #(
   parameter int A_WIDTH = 32,
   parameter int B_WIDTH = 32,
   parameter int P_WIDTH = A_WIDTH + B_WIDTH
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      valid_in,
   input  logic signed [A_WIDTH-1:0] multiplicand,
   input  logic signed [B_WIDTH-1:0] multiplier,
   input  logic signed [B_WIDTH-1:0] addend,
   output logic                      busy,
   output logic signed [P_WIDTH-1:0] result,
   output logic                      valid_out
);

   localparam int CW = $clog2(B_WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, LOOP, EPILOGUE} state_t;

   state_t               state;
   state_t               state_nxt;
   logic                 sign;
   logic [B_WIDTH-1:0]   addend_q;
   logic [A_WIDTH-1:0]   mcand;
   logic [B_WIDTH-1:0]   mplr;
   logic [P_WIDTH-1:0]   acc;
   logic [CW-1:0]        cnt;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (valid_in) state_nxt = LOOP;
         LOOP:     if (cnt == CW'(B_WIDTH - 1)) state_nxt = EPILOGUE;
         EPILOGUE: state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == LOOP) || (state == EPILOGUE);
   end

   // Magnitudes are held unsigned so that the most negative input maps to 2^(W-1).
   always_ff @(posedge clk) begin
      if (reset) begin
         sign      <= 1'b0;
         addend_q  <= '0;
         mcand     <= '0;
         mplr      <= '0;
         acc       <= '0;
         cnt       <= '0;
         result    <= '0;
         valid_out <= 1'b0;
      end else begin
         valid_out <= 1'b0;
         case (state)
            IDLE: begin
               if (valid_in) begin
                  sign     <= multiplicand[A_WIDTH-1] ^ multiplier[B_WIDTH-1];
                  addend_q <= addend;
                  mcand    <= multiplicand[A_WIDTH-1] ? -multiplicand : multiplicand;
                  mplr     <= multiplier[B_WIDTH-1] ? -multiplier : multiplier;
                  acc      <= '0;
                  cnt      <= '0;
               end
            end
            LOOP: begin
               if (mplr[0]) acc <= acc + (P_WIDTH'(mcand) << cnt);
               mplr <= mplr >> 1;
               cnt  <= cnt + CW'(1);
            end
            EPILOGUE: begin
               result    <= (sign ? -acc : acc) + {{A_WIDTH{addend_q[B_WIDTH-1]}}, addend_q};
               valid_out <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_acc.sv
// Directed bench for mul_acc: fixed vectors, busy/ignore behaviour, back-to-back and mid-op reset.
module tb_mul_acc;

   logic               clk = 1'b0;
   logic               reset;
   logic               valid_in;
   logic signed [31:0] multiplicand;
   logic signed [31:0] multiplier;
   logic signed [31:0] addend;
   logic               busy;
   logic signed [63:0] result;
   logic               valid_out;

   int total = 0;
   int bad   = 0;

   mul_acc #(.A_WIDTH(32), .B_WIDTH(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .valid_in     (valid_in),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .addend       (addend),
      .busy         (busy),
      .result       (result),
      .valid_out    (valid_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Accept one operation, then expect completion exactly 33 edges after the accept edge.
   task automatic do_op(input string tag, input logic signed [31:0] a, input logic signed [31:0] b,
                        input logic signed [31:0] c, input longint exp);
      int n;
      @(negedge clk);
      multiplicand = a;
      multiplier   = b;
      addend       = c;
      valid_in     = 1'b1;
      @(posedge clk);
      #1 valid_in = 1'b0;
      n = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (n == 1) chk({tag, "_busy"}, 64'(busy), 64'd1);
      end while (!valid_out && n < 100);
      chk({tag, "_lat"}, 64'(n), 64'd33);
      chk({tag, "_res"}, result, exp);
      chk({tag, "_idle"}, 64'(busy), 64'd0);
      @(negedge clk);
      chk({tag, "_pulse"}, 64'(valid_out), 64'd0);
      chk({tag, "_hold"}, result, exp);
   endtask

   initial begin
      int vo_cnt;
      int vo_at;
      longint vo_res;
      int t[3];
      int corner[5];
      logic signed [31:0] ra, rb, rc;

      reset = 1'b1;
      valid_in = 1'b0;
      multiplicand = '0;
      multiplier = '0;
      addend = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_result", result, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_vout", 64'(valid_out), 64'd0);
      reset = 1'b0;

      do_op("t1", 7, -3, 0, 64'hFFFF_FFFF_FFFF_FFEB);
      do_op("t2", 32'sh8000_0000, 32'sh8000_0000, 32'sh7FFF_FFFF, 64'h4000_0000_7FFF_FFFF);
      do_op("t3a", 142857, 7, 1, 1000000);
      do_op("t3b", -142857, 7, -1, -1000000);
      do_op("t4a", 0, -1, -5, -5);
      do_op("t4b", -1, -1, 0, 1);

      // valid_in pulses while busy must be dropped
      @(negedge clk);
      multiplicand = 3; multiplier = 5; addend = 1; valid_in = 1'b1;
      @(posedge clk);
      #1 valid_in = 1'b0;
      multiplicand = 100; multiplier = 100; addend = 100;
      vo_cnt = 0; vo_at = 0; vo_res = 0;
      for (int n = 1; n <= 60; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (valid_out) begin
            vo_cnt++;
            vo_at = n;
            vo_res = result;
         end
         valid_in = (n == 4) || (n == 9);
      end
      valid_in = 1'b0;
      chk("t5_count", 64'(vo_cnt), 64'd1);
      chk("t5_at", 64'(vo_at), 64'd33);
      chk("t5_res", vo_res, 64'd16);

      // continuous valid_in: a new op every 34 cycles
      multiplicand = 2; multiplier = 3; addend = 4; valid_in = 1'b1;
      vo_cnt = 0;
      for (int n = 1; n <= 120; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (valid_out) begin
            if (vo_cnt < 3) t[vo_cnt] = n;
            vo_cnt++;
            chk("t5b_res", result, 64'd10);
         end
      end
      valid_in = 1'b0;
      chk("t5b_count", 64'(vo_cnt), 64'd3);
      chk("t5b_first", 64'(t[0]), 64'd34);
      chk("t5b_gap1", 64'(t[1] - t[0]), 64'd34);
      chk("t5b_gap2", 64'(t[2] - t[1]), 64'd34);
      repeat (40) @(posedge clk);

      // reset while cnt=10 aborts the op
      @(negedge clk);
      multiplicand = 9; multiplier = 9; addend = 9; valid_in = 1'b1;
      @(posedge clk);
      #1 valid_in = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("t6_busy", 64'(busy), 64'd0);
      chk("t6_result", result, 64'd0);
      chk("t6_vout", 64'(valid_out), 64'd0);
      reset = 1'b0;
      vo_cnt = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (valid_out) vo_cnt++;
      end
      chk("t6_novout", 64'(vo_cnt), 64'd0);
      do_op("t6_fresh", -6, 11, 7, -59);

      // corner sweep
      corner[0] = 0; corner[1] = 1; corner[2] = -1;
      corner[3] = 32'sh7FFF_FFFF; corner[4] = 32'sh8000_0000;
      for (int i = 0; i < 5; i++) begin
         for (int j = 0; j < 5; j++) begin
            ra = corner[i];
            rb = corner[j];
            rc = corner[(i + j) % 5];
            do_op("corner", ra, rb, rc, longint'(ra) * longint'(rb) + longint'(rc));
         end
      end

      // random sweep
      for (int k = 0; k < 100; k++) begin
         ra = $urandom;
         rb = $urandom;
         rc = $urandom;
         do_op("rand", ra, rb, rc, longint'(ra) * longint'(rb) + longint'(rc));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
